adc_stream_capture: RTL and testbench

- Receiving end of the parallel ADC interface: the board's 10-bit ADC presents one sample per clock on GPIO.
- Registers each sample, optionally decimates it, and waits for an optional rising-level trigger.
- Captures a programmed number of samples into a small show-ahead FIFO, which drains over a valid/ready stream toward the SDRAM writer.
- Reports busy, done and sticky overflow status.

---
 rtl/adc_stream_capture.sv | 153 +++++++++++++++
 tb/tb_adc_stream_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_capture.sv
`default_nettype none
// ============================================================================
// adc_stream_capture - registers a parallel ADC stream, decimates, triggers,
// and buffers a fixed-length capture in a small show-ahead FIFO.
// Revision: 1.0
// ============================================================================
module adc_stream_capture #(
   parameter int DW        = 10,
   parameter int FIFO_LOG2 = 2,
   parameter int LEN_W     = 16
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic [DW-1:0]    adc_data,
   input  logic             arm,
   input  logic             trig_en,
   input  logic [DW-1:0]    trig_level,
   input  logic [7:0]       decim,
   input  logic [LEN_W-1:0] length,
   output logic [15:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam int DEPTH = 1 << FIFO_LOG2;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [FIFO_LOG2-1:0] PTR_ONE = 1;
   localparam logic [FIFO_LOG2:0]   CNT_ONE = 1;
   localparam logic [LEN_W-1:0]     LEN_ONE = 1;

   logic [1:0]           state;
   logic [DW-1:0]        s0;
   logic [DW-1:0]        s1;
   logic [DW-1:0]        trig_level_l;
   logic [7:0]           decim_l;
   logic [7:0]           dcnt;
   logic [LEN_W-1:0]     rem;
   logic [DW:0]          mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr;
   logic [FIFO_LOG2-1:0] rd_ptr;
   logic [FIFO_LOG2:0]   count;

   logic        trig_hit;
   logic        tick;
   logic        last;
   logic        full;
   logic        push;
   logic        pop;
   logic [DW:0] head;
   logic [15:0] data_word;

   always_comb begin
      trig_hit  = (state == S_WAIT) && (s1 < trig_level_l) && (s0 >= trig_level_l);
      tick      = trig_hit || ((state == S_CAPTURE) && (dcnt == 8'd0));
      last      = (rem == LEN_ONE);
      // Occupancy never exceeds DEPTH, so the top count bit alone means full.
      full      = count[FIFO_LOG2];
      push      = tick && !full;
      out_valid = (count != '0);
      pop       = out_valid && out_ready;
      busy      = (state == S_WAIT) || (state == S_CAPTURE);
      done      = (state == S_DONE);
      head      = mem[rd_ptr];
      data_word = '0;
      data_word[DW-1:0] = head[DW-1:0];
      data_word[15]     = head[DW];
      out_data  = out_valid ? data_word : 16'd0;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state        <= S_IDLE;
         s0           <= '0;
         s1           <= '0;
         trig_level_l <= '0;
         decim_l      <= '0;
         dcnt         <= '0;
         rem          <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
      end else begin
         s0 <= adc_data;
         s1 <= s0;
         if (arm) begin
            // A new arm wins over any tick or pop in the same cycle.
            trig_level_l <= trig_level;
            decim_l      <= decim;
            dcnt         <= '0;
            rem          <= length;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            if (length == '0) begin
               state <= S_DONE;
            end else if (trig_en) begin
               state <= S_WAIT;
            end else begin
               state <= S_CAPTURE;
            end
         end else begin
            if (trig_hit) begin
               dcnt <= '0;
            end else if (state == S_CAPTURE) begin
               dcnt <= (dcnt == decim_l) ? 8'd0 : dcnt + 8'd1;
            end

            if (tick) begin
               rem <= rem - LEN_ONE;
               if (full) begin
                  overflow <= 1'b1;
               end
               if (last) begin
                  state <= S_DONE;
               end else if (trig_hit) begin
                  state <= S_CAPTURE;
               end
            end

            if (push) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
               count <= count + CNT_ONE;
            end else if (!push && pop) begin
               count <= count - CNT_ONE;
            end
         end
      end
   end

   // Storage has no reset; entries are only visible behind a nonzero count.
   always_ff @(posedge clk) begin
      if (n_reset && !arm && push) begin
         mem[wr_ptr] <= {last, s0};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_stream_capture.sv
`default_nettype none
// tb_adc_stream_capture - directed self-checking bench for adc_stream_capture.
module tb_adc_stream_capture;

   localparam int DW    = 10;
   localparam int LEN_W = 16;

   logic             clk        = 1'b0;
   logic             n_reset    = 1'b0;
   logic [DW-1:0]    adc_data   = '0;
   logic             arm        = 1'b0;
   logic             trig_en    = 1'b0;
   logic [DW-1:0]    trig_level = '0;
   logic [7:0]       decim      = '0;
   logic [LEN_W-1:0] length     = '0;
   logic             out_ready  = 1'b1;
   logic [15:0]      out_data;
   logic             out_valid;
   logic             busy;
   logic             done;
   logic             overflow;

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] base     = '0;

   adc_stream_capture #(
      .DW        (DW),
      .FIFO_LOG2 (2),
      .LEN_W     (LEN_W)
   ) dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .adc_data   (adc_data),
      .arm        (arm),
      .trig_en    (trig_en),
      .trig_level (trig_level),
      .decim      (decim),
      .length     (length),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Free-running 10-bit ramp, updated just after each rising edge.
   always @(posedge clk) begin
      #1;
      adc_data = adc_data + DW'(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] word(input logic [DW-1:0] v, input bit lst);
      word = {lst, 5'd0, v};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Arms at the current negedge; base is the sample taken at the arm edge.
   task automatic arm_cfg(input bit te, input logic [DW-1:0] lvl,
                          input logic [7:0] dc, input logic [LEN_W-1:0] len);
      arm        = 1'b1;
      trig_en    = te;
      trig_level = lvl;
      decim      = dc;
      length     = len;
      base       = adc_data;
      step();
      arm = 1'b0;
   endtask

   task automatic arm_at(input logic [DW-1:0] target, input bit te,
                         input logic [DW-1:0] lvl, input logic [7:0] dc,
                         input logic [LEN_W-1:0] len);
      int n = 0;
      while (adc_data !== target && n < 1100) begin
         step();
         n++;
      end
      chk("ramp_reach", 32'(n < 1100), 32'd1);
      step();
      arm_cfg(te, lvl, dc, len);
   endtask

   initial begin
      int cyc;
      int nvalid;
      logic [DW-1:0] e;

      // 1: reset with toggling data, then idle after release
      for (int i = 0; i < 5; i++) begin
         step();
         chk("reset_outs", {out_valid, busy, done, overflow, out_data}, 32'd0);
      end
      n_reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_outs", {out_valid, busy, done, overflow, out_data}, 32'd0);
      end

      // 2: immediate capture, 8 consecutive words
      out_ready = 1'b1;
      arm_at(10'h010, 1'b0, '0, 8'd0, 16'd8);
      chk("t2_base", 32'(base), 32'h011);
      chk("t2_busy0", {busy, out_valid}, 32'b10);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t2_valid", 32'(out_valid), 32'd1);
         chk("t2_data", 32'(out_data), 32'(word(base + DW'(i), i == 7)));
      end
      chk("t2_done_at_last", 32'(done), 32'd1);
      step();
      chk("t2_after", {done, busy, out_valid, overflow}, 32'b1000);

      // 3: decimate by 4, length 4
      arm_at(10'h040, 1'b0, '0, 8'd3, 16'd4);
      chk("t3_k0", {busy, out_valid}, 32'b10);
      for (int k = 1; k <= 16; k++) begin
         step();
         if ((k % 4) == 1 && k <= 13) begin
            chk("t3_valid", 32'(out_valid), 32'd1);
            chk("t3_data", 32'(out_data), 32'(word(base + DW'(k - 1), k == 13)));
         end else begin
            chk("t3_gap", 32'(out_valid), 32'd0);
         end
      end
      chk("t3_done", {done, overflow}, 32'b10);

      // 4: rising-level trigger at 0x200
      arm_at(10'h100, 1'b1, 10'h200, 8'd0, 16'd3);
      chk("t4_busy", {busy, out_valid}, 32'b10);
      cyc = 0;
      while (!out_valid && cyc < 400) begin
         step();
         cyc++;
         if (!out_valid) chk("t4_wait_busy", 32'(busy), 32'd1);
      end
      chk("t4_latency", 32'(cyc), 32'd256);
      chk("t4_w0", 32'(out_data), 32'h0200);
      step();
      chk("t4_w1", {out_valid, out_data}, {1'b1, 16'h0201});
      step();
      chk("t4_w2", {out_valid, out_data}, {1'b1, 16'h8202});
      step();
      chk("t4_done", {done, busy, out_valid}, 32'b100);
      nvalid = 0;
      for (int i = 0; i < 16'h220; i++) begin
         step();
         if (out_valid) nvalid++;
      end
      chk("t4_no_retrig", 32'(nvalid), 32'd0);
      chk("t4_done_hold", 32'(done), 32'd1);

      // 5: stalled consumer, overflow drops the tail including the last word
      out_ready = 1'b0;
      arm_cfg(1'b0, '0, 8'd0, 16'd6);
      repeat (7) step();
      chk("t5_status", {overflow, done, busy, out_valid}, 32'b1101);
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         e = base + DW'(j);
         chk("t5_drain", {out_valid, out_data}, {1'b1, word(e, 1'b0)});
         step();
      end
      chk("t5_empty", 32'(out_valid), 32'd0);

      // 6a: zero length goes straight to DONE, also clears overflow
      arm_cfg(1'b0, '0, 8'd0, 16'd0);
      chk("t6_len0", {done, busy, out_valid, overflow}, 32'b1000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_len0_hold", {busy, out_valid}, 32'b00);
      end

      // 6b: re-arm mid-capture with two words queued
      out_ready = 1'b0;
      arm_cfg(1'b0, '0, 8'd0, 16'd10);
      step();
      step();
      chk("t6_queued", {out_valid, out_data}, {1'b1, word(base, 1'b0)});
      out_ready = 1'b1;
      arm_cfg(1'b0, '0, 8'd0, 16'd5);
      chk("t6_flushed", {out_valid, busy, overflow}, 32'b010);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t6_restart", {out_valid, out_data}, {1'b1, word(base + DW'(i), i == 4)});
      end
      step();
      chk("t6_end", {done, out_valid}, 32'b10);

      // Reset in the middle of a capture discards the queue
      out_ready = 1'b0;
      arm_cfg(1'b0, '0, 8'd0, 16'd10);
      step();
      step();
      chk("rst_mid_pre", 32'(out_valid), 32'd1);
      n_reset = 1'b0;
      step();
      chk("rst_mid", {out_valid, busy, done, overflow, out_data}, 32'd0);
      n_reset = 1'b1;
      step();
      chk("rst_mid_idle", {out_valid, busy, done}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
